// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor sequencer: FSM states, PWM slot count,
// coil one-hot lookup and duty clamping.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2
  } state_t;

  localparam int DUTY_SLOTS = 10;

  function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b1000;
      2'd1:    oh = 4'b0100;
      2'd2:    oh = 4'b0010;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  function automatic logic [3:0] clamp_duty(input logic [3:0] d);
    return (d > 4'(DUTY_SLOTS)) ? 4'(DUTY_SLOTS) : d;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings an asynchronous divided-clock level into the clk domain and emits a
// one-cycle strobe per rising edge.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic strobe
);

  logic sync1, sync2, sync3;

  // Strobe is registered so a rise sampled at edge k acts on the FSM at edge k+3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1  <= level;
      sync2  <= sync1;
      sync3  <= sync2;
      strobe <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/motor_sequencer.sv
// Command-driven stepper + DC motor sequencer: runs N full steps with a 10-slot
// DC PWM, then brakes for BRAKE_SLOTS DC slots and pulses done.
module motor_sequencer
  import motor_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int BRAKE_SLOTS = 20,
  parameter int DUTY_SLOTS  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stp_clk_in,
  input  logic              dc_clk_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_cw,
  input  logic [3:0]        cmd_duty,
  input  logic              cmd_dc_fwd,
  input  logic              abort,
  output logic [3:0]        stp_phase,
  output logic              dc_pwm,
  output logic              dc_fwd,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(BRAKE_SLOTS + 1);

  logic stp_stb, dc_stb;

  tick_sync u_stp_sync (.clk(clk), .rst_n(rst_n), .level(stp_clk_in), .strobe(stp_stb));
  tick_sync u_dc_sync  (.clk(clk), .rst_n(rst_n), .level(dc_clk_in),  .strobe(dc_stb));

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [STEP_W-1:0] remaining;
  logic [3:0]        slot, duty;
  logic              cw;
  logic [BW-1:0]     brake_cnt;
  logic              accept, step_go;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_go   = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    stp_phase = phase_onehot(idx);
    dc_pwm    = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        stp_phase = 4'b0000;
        cmd_ready = ~abort;
        if (cmd_valid && !abort) begin
          accept    = 1'b1;
          state_nxt = (cmd_steps != '0) ? RUN : BRAKE;
        end
      end
      RUN: begin
        dc_pwm  = (slot < duty);
        step_go = stp_stb & ~abort;
        if (abort || (stp_stb && remaining == STEP_W'(1))) state_nxt = BRAKE;
      end
      BRAKE: begin
        if (dc_stb && brake_cnt == BW'(BRAKE_SLOTS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      remaining <= '0;
      slot      <= 4'd0;
      duty      <= 4'd0;
      cw        <= 1'b0;
      dc_fwd    <= 1'b0;
      brake_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == BRAKE) && (state_nxt == IDLE);
      if (accept) begin
        remaining <= cmd_steps;
        cw        <= cmd_cw;
        duty      <= clamp_duty(cmd_duty);
        dc_fwd    <= cmd_dc_fwd;
      end
      // Phase index is never cleared between commands; only reset returns it to 0.
      if (step_go) begin
        idx       <= cw ? idx + 2'd1 : idx - 2'd1;
        remaining <= remaining - STEP_W'(1);
      end
      if (state == RUN && dc_stb)
        slot <= (slot == 4'(DUTY_SLOTS - 1)) ? 4'd0 : slot + 4'd1;
      if (state != BRAKE)
        brake_cnt <= '0;
      else if (dc_stb)
        brake_cnt <= brake_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with a cycle-level reference model and
// hand-computed phase sequences.
module tb_motor_sequencer;

  localparam int STEP_W      = 16;
  localparam int BRAKE_SLOTS = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stp_clk_in = 1'b0, dc_clk_in = 1'b0;
  logic              cmd_valid = 1'b0, cmd_cw = 1'b0, cmd_dc_fwd = 1'b0, abort = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic [3:0]        cmd_duty = 4'd0;
  logic              cmd_ready, dc_pwm, dc_fwd, busy, done;
  logic [3:0]        stp_phase;

  motor_sequencer #(.STEP_W(STEP_W), .BRAKE_SLOTS(BRAKE_SLOTS), .DUTY_SLOTS(10)) dut (
    .clk(clk), .rst_n(rst_n), .stp_clk_in(stp_clk_in), .dc_clk_in(dc_clk_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_cw(cmd_cw), .cmd_duty(cmd_duty), .cmd_dc_fwd(cmd_dc_fwd), .abort(abort),
    .stp_phase(stp_phase), .dc_pwm(dc_pwm), .dc_fwd(dc_fwd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Free-running divided clocks: stepper period 8 clk, DC period 4 clk.
  int stp_cnt = 0, dc_cnt = 0;
  initial forever begin
    @(posedge clk);
    #2;
    stp_cnt++;
    if (stp_cnt == 4) begin stp_cnt = 0; stp_clk_in = ~stp_clk_in; end
    dc_cnt++;
    if (dc_cnt == 2) begin dc_cnt = 0; dc_clk_in = ~dc_clk_in; end
  end

  // Reference model: mode 0 idle, 1 run, 2 brake. Divided-clock rises act 3 edges after first sampling.
  int m_mode = 0, m_idx = 0, m_rem = 0, m_slot = 0, m_duty = 0, m_bcnt = 0;
  bit m_cw = 0, m_fwd = 0, m_done = 0;
  bit stp_prev = 0, dc_prev = 0, stp_ev, dc_ev;
  bit stp_d[3], dc_d[3];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_rem = 0; m_slot = 0; m_duty = 0; m_bcnt = 0;
      m_cw = 0; m_fwd = 0; m_done = 0; stp_prev = 0; dc_prev = 0;
      for (int i = 0; i < 3; i++) begin stp_d[i] = 0; dc_d[i] = 0; end
    end else begin
      stp_ev = stp_d[2]; stp_d[2] = stp_d[1]; stp_d[1] = stp_d[0];
      stp_d[0] = stp_clk_in && !stp_prev; stp_prev = stp_clk_in;
      dc_ev = dc_d[2]; dc_d[2] = dc_d[1]; dc_d[1] = dc_d[0];
      dc_d[0] = dc_clk_in && !dc_prev; dc_prev = dc_clk_in;
      m_done = 0;
      if (m_mode == 0) begin
        if (cmd_valid && !abort) begin
          m_rem  = int'(cmd_steps);
          m_cw   = cmd_cw;
          m_fwd  = cmd_dc_fwd;
          m_duty = (cmd_duty > 10) ? 10 : int'(cmd_duty);
          m_bcnt = 0;
          m_mode = (cmd_steps != 0) ? 1 : 2;
        end
      end else if (m_mode == 1) begin
        if (dc_ev) m_slot = (m_slot + 1) % 10;
        if (abort) begin
          m_mode = 2; m_bcnt = 0;
        end else if (stp_ev) begin
          m_idx = (m_idx + (m_cw ? 1 : 3)) % 4;
          m_rem--;
          if (m_rem == 0) begin m_mode = 2; m_bcnt = 0; end
        end
      end else begin
        if (dc_ev) begin
          m_bcnt++;
          if (m_bcnt == BRAKE_SLOTS) begin m_mode = 0; m_done = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0] oh, ep;
    logic [8:0] act, exp;
    oh  = 4'b1000;
    ep  = (m_mode == 0) ? 4'b0000 : (oh >> m_idx);
    act = {stp_phase, dc_pwm, dc_fwd, busy, done, cmd_ready};
    exp = {ep, (m_mode == 1) && (m_slot < m_duty), m_fwd, m_mode != 0, m_done,
           (m_mode == 0) && !abort};
    check("cycle_outputs", 32'(act), 32'(exp));
  end

  // Observation: handshakes, done pulses, PWM activity, distinct energized phases.
  int hs_cnt = 0, done_cnt = 0, cyc = 0, hs_cyc = -1, done_cyc = -1;
  bit pwm_seen = 0;
  logic [3:0] last_phase = 4'b0000;
  logic [3:0] phase_q[$];
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin hs_cnt++; hs_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dc_pwm) pwm_seen = 1;
    if (stp_phase != last_phase) begin
      if (stp_phase != 4'b0000) phase_q.push_back(stp_phase);
      last_phase = stp_phase;
    end
    cyc++;
  end

  function automatic logic [31:0] pack_q();
    logic [31:0] v = 0;
    foreach (phase_q[i]) v = (v << 4) | 32'(phase_q[i]);
    return v;
  endfunction

  task automatic send_cmd(input int steps, input bit cw, input int duty, input bit fwd);
    int h0 = hs_cnt;
    bit ok = 0;
    @(posedge clk); #2;
    cmd_valid = 1; cmd_steps = STEP_W'(steps); cmd_cw = cw;
    cmd_duty = 4'(duty); cmd_dc_fwd = fwd;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (hs_cnt != h0) ok = 1;
    end
    #2 cmd_valid = 0;
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      if (done_cnt != d0) ok = 1;
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int h0, d0;
    bit ok;
    repeat (3) @(posedge clk);
    #1 check("reset_state", {27'd0, stp_phase, dc_pwm, busy, done, cmd_ready}, 32'h0000_0001);
    @(posedge clk); #2 rst_n = 1;
    repeat (5) @(posedge clk);

    // Basic run: 5 steps cw from index 0.
    phase_q.delete(); d0 = done_cnt;
    send_cmd(5, 1, 3, 1);
    wait_done();
    check("basic_phase_seq", pack_q(), 32'h0084_2184);
    check("basic_done_once", 32'(done_cnt - d0), 32'd1);

    // Reverse, index persists from 0100.
    repeat (3) @(posedge clk);
    phase_q.delete();
    send_cmd(2, 0, 5, 0);
    wait_done();
    check("reverse_phase_seq", pack_q(), 32'h0000_0481);

    // Zero steps with over-range duty: straight to brake, no PWM.
    repeat (3) @(posedge clk);
    pwm_seen = 0;
    send_cmd(0, 1, 15, 1);
    wait_done();
    check("zero_steps_no_pwm", 32'(pwm_seen), 32'd0);

    // Clamped full duty in RUN.
    repeat (3) @(posedge clk);
    pwm_seen = 0; phase_q.delete();
    send_cmd(3, 1, 15, 0);
    wait_done();
    check("duty15_pwm_on", 32'(pwm_seen), 32'd1);
    check("duty15_phase_seq", pack_q(), 32'h0000_1842);

    // Abort after two advances of a 100-step command (index starts at 2).
    repeat (3) @(posedge clk);
    phase_q.delete();
    send_cmd(100, 1, 4, 1);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (phase_q.size() >= 3) ok = 1;
    end
    check("abort_reach_step2", 32'(ok), 32'd1);
    #2 abort = 1;
    repeat (4) @(posedge clk);
    #2 abort = 0;
    wait_done();
    check("abort_phase_seq", pack_q(), 32'h0000_0218);

    // Abort in IDLE blocks the handshake.
    repeat (3) @(posedge clk);
    #2 abort = 1; cmd_valid = 1; cmd_steps = 16'd1; cmd_cw = 1; cmd_duty = 4'd2;
    h0 = hs_cnt;
    repeat (10) @(posedge clk);
    #2 check("abort_idle_ready", 32'(cmd_ready), 32'd0);
    check("abort_idle_no_hs", 32'(hs_cnt - h0), 32'd0);
    abort = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      if (hs_cnt != h0) ok = 1;
    end
    #2 cmd_valid = 0;
    check("abort_release_accept", 32'(ok), 32'd1);
    wait_done();

    // Back-to-back: valid held across done.
    repeat (3) @(posedge clk);
    h0 = hs_cnt;
    #2 cmd_valid = 1; cmd_steps = 16'd2; cmd_cw = 1; cmd_duty = 4'd5; cmd_dc_fwd = 1;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      if (hs_cnt - h0 >= 2) ok = 1;
    end
    #2 cmd_valid = 0;
    check("b2b_second_accept", 32'(ok), 32'd1);
    check("b2b_accept_after_done", 32'(hs_cyc), 32'(done_cyc));
    wait_done();
    check("b2b_one_hs_each", 32'(hs_cnt - h0), 32'd2);

    // Asynchronous reset mid-RUN.
    repeat (3) @(posedge clk);
    phase_q.delete(); d0 = done_cnt;
    send_cmd(50, 1, 5, 1);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (phase_q.size() >= 2) ok = 1;
    end
    #3 rst_n = 0;
    #1 check("async_reset_outputs", {26'd0, stp_phase, dc_pwm, dc_fwd, busy, done},
             32'd0);
    check("async_reset_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
    check("reset_no_done", 32'(done_cnt - d0), 32'd0);
    phase_q.delete();
    send_cmd(1, 1, 5, 0);
    wait_done();
    check("post_reset_phase_seq", pack_q(), 32'h0000_0084);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Command-driven controller that sequences the car's stepper motor and DC motor from the divided motor clocks produced by the clock divisor. It accepts one move command at a time over a valid/ready handshake. It runs the stepper for a commanded number of full steps while driving the DC motor with a 10-slot PWM. It then brakes for a fixed number of DC slots and reports completion. Sits between the command decoder (remote-control receiver) and the motor driver pins.

## Interface
- STEP_W, 16, width of the step count.
- BRAKE_SLOTS, 20, DC slots held in BRAKE before returning to IDLE (must be ≥1).
- DUTY_SLOTS, 10, PWM slots per DC period; fixed, do not override.

- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- stp_clk_in  in  1  divided stepper clock, treated as asynchronous level; each rising edge is one step tick.
- dc_clk_in  in  1  divided DC clock, treated as asynchronous level; each rising edge is one PWM slot tick.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE with abort low.
- cmd_steps  in  STEP_W  number of full steps.
- cmd_cw  in  1  stepper direction, 1 = clockwise.
- cmd_duty  in  4  DC duty in slots, 0..10; values >10 are clamped to 10.
- cmd_dc_fwd  in  1  DC direction.
- abort  in  1  level; forces BRAKE from any non-IDLE state.
- stp_phase  out  4  one-hot coil drive.
- dc_pwm  out  1  PWM to the DC driver enable.
- dc_fwd  out  1  latched DC direction.
- busy  out  1  high in RUN or BRAKE.
- done  out  1  one-cycle pulse on BRAKE→IDLE.

## Operation
- Reset values:
  - Outputs: stp_phase = 0000, dc_pwm = 0, dc_fwd = 0, busy = 0, done = 0, cmd_ready = 1.
  - Internal: phase index = 0, slot counter = 0, state = IDLE.
- Tick strobes:
  - Each divided-clock input passes through a 2-flop synchronizer plus an edge-detect flop.
  - Strobe = sync2 & ~sync3, one clk cycle wide per rising edge.
- IDLE:
  - stp_phase = 0000 (coils off); dc_pwm = 0.
  - Handshake completes when cmd_valid & cmd_ready.
  - On acceptance: latch steps, direction, clamped duty and dc_fwd.
  - If cmd_steps ≠ 0, go to RUN; if cmd_steps = 0, go to BRAKE.
- RUN:
  - stp_phase = one-hot of phase index. Index 0..3 maps to 1000, 0100, 0010, 0001.
  - On each step strobe:
    - Index advances +1 mod 4 when cw, −1 mod 4 otherwise.
    - Remaining count decrements.
    - On the strobe that makes the count 0, go to BRAKE. The phase advances on that strobe too, so exactly N advances occur.
  - dc_pwm = (slot < duty). Slot advances on each DC strobe and wraps 9→0.
- BRAKE:
  - stp_phase holds the last one-hot value (holding torque); dc_pwm = 0.
  - Counts BRAKE_SLOTS DC strobes, then goes to IDLE with done = 1 for one cycle.
- abort:
  - In RUN, go to BRAKE on the next clk; the remaining count is discarded.
  - In BRAKE, no effect.
  - In IDLE, it only holds cmd_ready low.
- The phase index persists across commands; it is cleared only by reset.
- Duty 0 gives dc_pwm constantly 0. Duty 10 gives dc_pwm constantly 1 during RUN.
- A step strobe and a DC strobe in the same cycle are processed independently in that cycle.
- A DC strobe in the same cycle as the final step strobe counts toward RUN's PWM, not toward BRAKE.

## Timing
- Divided-clock input rise first sampled at edge k → strobe high after edge k+2 → resulting output change at edge k+3.
- Command accepted at edge k:
  - busy = 1 and cmd_ready = 0 from edge k.
  - In RUN, stp_phase is energized from edge k.
  - dc_pwm is valid from edge k, using the current slot value.
- done asserts at the edge that enters IDLE. cmd_ready = 1 in that same cycle, so a back-to-back command is accepted on the next edge.
- Reset deassertion: the first strobe can occur no earlier than 3 clk edges later.
- Asynchronous reset mid-command: all outputs go to reset values immediately, with no done pulse.

## Structure
- Package motor_pkg:
  - State enum IDLE/RUN/BRAKE.
  - DUTY_SLOTS = 10.
  - 4-entry phase-to-one-hot lookup function.
  - Duty clamp function.
- Sub-module tick_sync: 2-flop synchronizer plus rising-edge strobe; instantiated twice (stepper, DC).
- Top: FSM, step counter, phase index, slot counter, brake counter.

## Test plan
- Basic run:
  - Stimulus: cmd steps=5, cw=1, duty=3, from index 0.
  - Response: stp_phase sequence 1000→0100→0010→0001→1000→0100, then BRAKE holding 0100.
  - Response: dc_pwm high 3 of every 10 DC slots during RUN.
  - Response: done pulses once after 20 DC strobes in BRAKE.
- Reverse and persistence:
  - Stimulus: after the basic run, cmd steps=2, cw=0.
  - Response: 0100→1000→0001.
- Edge cases:
  - Stimulus: steps=0, duty=15.
  - Response: straight to BRAKE, dc_pwm never 1, done after 20 DC strobes.
  - Stimulus: a separate command with duty=15 in RUN.
  - Response: clamped to 10, dc_pwm constantly 1 in RUN.
- Abort:
  - Stimulus: abort during RUN at step 2 of 100.
  - Response: BRAKE on the next clk, done after BRAKE_SLOTS.
  - Stimulus: abort = 1 with cmd_valid = 1 in IDLE.
  - Response: cmd_ready = 0, command not accepted.
- Back-to-back: cmd_valid held high across done.
  - Response: second command accepted on the cycle after done; exactly one handshake per command.
- Reset mid-RUN:
  - Stimulus: rst_n low asynchronously between clk edges.
  - Response: stp_phase = 0000, busy = 0, cmd_ready = 1 immediately.
  - Response after release: first step advances from index 0, no earlier than 3 edges.
